// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
//   UART receive front end, 8N1, LSB first. The RX line is synchronised and
//   its falling edge detected. Each bit is sampled once at its centre. The
//   assembled byte goes to po_data with a one-cycle po_flag strobe. A
//   start-bit glitch returns the receiver to idle with no output. A low stop
//   bit discards the byte and raises a one-cycle frame_err strobe.
//
// Parameters
//   UART_BPS  : line baud rate
//   CLK_FREQ  : clk frequency in Hz
//   The derived value CLK_FREQ/UART_BPS (clocks per bit) must be >= 8.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : asynchronous serial input, idle high
//   po_data   : last good byte received, bit0 = first data bit on the line
//   po_flag   : one-cycle strobe, po_data has just been updated
//   frame_err : one-cycle strobe, stop bit was low and the byte was dropped
// ---------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF_BIT     = BAUD_CNT_MAX / 2;
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_reg_q, shift_reg_d;
  logic [7:0]       po_data_q, po_data_d;
  logic             po_flag_q, po_flag_d;
  logic             frame_err_q, frame_err_d;

  logic             rx_s1_q, rx_s2_q, rx_s3_q;
  logic             fd;
  logic             tick;

  // Input conditioning: two flops to resolve metastability, a third flop so
  // the falling edge can be seen. All three reset high, so reset release
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
    end
  end

  assign fd = rx_s3_q & ~rx_s2_q;

  // Sample tick. The first tick comes half a bit after the falling edge, at
  // the start-bit centre. Every later tick comes one full bit after the
  // previous one, so all samples land at bit centre.
  always_comb begin
    tick = 1'b0;
    case (state_q)
      START:       tick = (baud_cnt_q == HALF_LAST);
      DATA, STOP:  tick = (baud_cnt_q == BIT_LAST);
      default:     tick = 1'b0;
    endcase
  end

  // State and datapath registers. A reset in the middle of a frame drops the
  // frame at once, so a partial byte is never flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_reg_q <= '0;
      po_data_q   <= '0;
      po_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      po_data_q   <= po_data_d;
      po_flag_q   <= po_flag_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic. The FSM leaves STOP at the stop-bit centre, which
  // leaves half a bit of margin to catch a start bit that follows at once.
  // rx_s2 is the only point where the line is sampled.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    po_data_d   = po_data_q;
    po_flag_d   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q != IDLE) begin
      baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fd) begin
          state_d    = START;
          baud_cnt_d = '0;
        end
      end
      START: begin
        // A line that is high again at the start-bit centre was a glitch.
        if (tick) begin
          if (rx_s2_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        // Data arrives LSB first, so each bit enters at the MSB and moves down.
        if (tick) begin
          shift_reg_d = {rx_s2_q, shift_reg_q[7:1]};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s2_q) begin
            po_data_d = shift_reg_q;
            po_flag_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign po_data   = po_data_q;
  assign po_flag   = po_flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- Serial-to-parallel UART receive front end, 8N1 format, LSB first.
- Sits directly upstream of the UART-to-write-FIFO packer.
- Its po_data/po_flag pair is the byte stream that the packer accumulates into FIFO-width words.
- Adds start-bit glitch rejection and a framing-error strobe.

Parameters:
UART_BPS, 9600, line baud rate
CLK_FREQ, 50_000_000, clk frequency in Hz
- Derived (localparam), not overridable:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division), clocks per bit.
  - HALF_BIT = BAUD_CNT_MAX/2.
- Legal range: BAUD_CNT_MAX >= 8.
- Baud counter width = clog2(BAUD_CNT_MAX).

Ports:
clk        input   1  system clock, all logic on rising edge
rst_n      input   1  asynchronous active-low reset; release is synchronous to clk at the caller
rx         input   1  asynchronous RS232 RX line, idle high
po_data    output  8  received byte, bit0 = first data bit on the line
po_flag    output  1  one-cycle strobe: po_data holds a new valid byte
frame_err  output  1  one-cycle strobe: stop bit sampled low, byte discarded

Behaviour:
- Reset:
  - po_data = 8'h00, po_flag = 0, frame_err = 0.
  - State IDLE, counters 0.
  - Synchroniser flops reset to 1, so reset release never looks like a falling edge.
  - Reset mid-frame aborts the frame immediately; no partial byte is ever flagged.
- Input conditioning:
  - rx passes through 2 flops (rx_s1, rx_s2), then a third flop rx_s3.
  - Falling edge fd = rx_s3 & ~rx_s2.
- Baud counter (baud_cnt):
  - Cleared on entry to START.
  - Cleared on every sample tick; otherwise increments while state != IDLE.
- Sample tick:
  - START: baud_cnt == HALF_BIT-1.
  - DATA/STOP: baud_cnt == BAUD_CNT_MAX-1.
  - Every sample therefore lands at bit centre.
- FSM:
  - IDLE: on fd go to START; fd is ignored in all other states.
  - START: at tick sample rx_s2.
    - rx_s2 = 1: glitch; return to IDLE with no output.
    - rx_s2 = 0: go to DATA, bit_cnt = 0.
  - DATA: at each tick shift rx_s2 into shift_reg MSB (right shift) and increment bit_cnt. At the tick with bit_cnt == 7 go to STOP.
  - STOP: at tick sample rx_s2.
    - 1: next cycle po_data <= shift_reg, po_flag = 1.
    - 0: next cycle frame_err = 1; po_data keeps its previous value.
    - Either way go to IDLE at the tick.
- Back-to-back frames:
  - Returning to IDLE at stop-bit centre leaves half a bit of margin.
  - A start bit immediately after a single stop bit must be caught.
- Outputs:
  - po_flag and frame_err are registered, never both high, and high exactly one cycle per frame.
  - po_data is stable between po_flag strobes.
- Latency:
  - From first clk seeing rx low: 3 sync cycles, then HALF_BIT + 9*BAUD_CNT_MAX cycles to the stop tick.
  - po_flag follows the stop tick by 1 cycle.
- rx is assumed asynchronous; the only sample point is rx_s2.

Test Plan:
- Bench parameters: CLK_FREQ=50_000_000, UART_BPS=5_000_000, giving BAUD_CNT_MAX=10 and HALF_BIT=5. Bit period = 10 clk.
1. Idle rx=1 for 500 clk, then frame 0x55 -> exactly one po_flag, po_data=8'h55, frame_err=0. po_flag arrives 3+5+90+1 cycles after rx falls (±1 for sync alignment).
2. Frames 0xA5 and 0x3C back-to-back with one stop bit -> two po_flag strobes 100 clk apart, po_data 8'hA5 then 8'h3C, no frame_err.
3. rx low for 3 clk then high, then frame 0x81 -> no output from the glitch, state back to IDLE. Then one po_flag with po_data=8'h81.
4. Frame 0x12 received, then 0xFF sent with stop bit forced 0 -> frame_err one-cycle pulse, po_flag stays 0, po_data remains 8'h12. Next clean frame 0x34 gives po_flag with 8'h34.
5. Assert rst_n low during data bit 4 of frame 0x6B -> po_data=0, po_flag=0, frame_err=0 immediately, and no strobe for the aborted frame. After release with rx idle, frame 0xC3 gives po_data=8'hC3.
6. Random 200-byte stream with ±2% baud skew (bit period 9.8 or 10.2 clk, bench models fractional period) -> every byte reconstructed with no frame_err.
